// File: rtl/ff_d_pkg.sv
// ============================================================================
//  Module      : ff_d_pkg
//  Description : Shared constants and helpers for the ff_d register family.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ff_d_pkg;

    localparam int WIDTH_DEFAULT = 1;
    localparam int MAX_WIDTH     = 64;

    // Right-shifting a full ones word leaves exactly `width` low ones set.
    function automatic logic [MAX_WIDTH-1:0] all_ones(input int width);
        return {MAX_WIDTH{1'b1}} >> (MAX_WIDTH - width);
    endfunction

endpackage

`default_nettype wire

// File: rtl/ff_d_bit.sv
// ============================================================================
//  Module      : ff_d_bit
//  Description : Single-bit D cell with load enable and synchronous reset.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ff_d_bit (
    input  logic clock,
    input  logic reset,
    input  logic en,
    input  logic d,
    input  logic rst_val,
    output logic q
);

    always_ff @(posedge clock) begin
        if (reset) begin
            q <= rst_val;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/ff_d.sv
// ============================================================================
//  Module      : ff_d
//  Description : WIDTH-bit D register with load enable and synchronous reset.
//                Define FF_D_QN_EN to add the inverted output qn.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ff_d
    import ff_d_pkg::*;
#(
    parameter int               WIDTH       = WIDTH_DEFAULT,
    parameter logic [WIDTH-1:0] RESET_VALUE = WIDTH'(all_ones(WIDTH))
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
`ifdef FF_D_QN_EN
    ,
    output logic [WIDTH-1:0] qn
`endif
);

    if (WIDTH < 1 || WIDTH > MAX_WIDTH) begin : g_bad_width
        $error("ff_d: WIDTH=%0d outside legal range 1..%0d", WIDTH, MAX_WIDTH);
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        ff_d_bit u_bit (
            .clock   (clock),
            .reset   (reset),
            .en      (en),
            .d       (d[i]),
            .rst_val (RESET_VALUE[i]),
            .q       (q[i])
        );
    end

`ifdef FF_D_QN_EN
    // Derived from state only, so qn resets to ~RESET_VALUE automatically.
    assign qn = ~q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_ff_d.sv
// ============================================================================
//  Module      : tb_ff_d
//  Description : Directed self-checking bench for ff_d at WIDTH=3.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ff_d;

    localparam int TB_W = 3;

    logic            clock;
    logic            reset;
    logic            en;
    logic [TB_W-1:0] d;
    logic [TB_W-1:0] q;
`ifdef FF_D_QN_EN
    logic [TB_W-1:0] qn;
`endif

    int n_checks;
    int n_errors;

    ff_d #(
        .WIDTH (TB_W)
    ) dut (
        .clock (clock),
        .reset (reset),
        .en    (en),
        .d     (d),
        .q     (q)
`ifdef FF_D_QN_EN
        ,
        .qn    (qn)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_value(input string tag, input logic [TB_W-1:0] got,
                               input logic [TB_W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle just past it.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        reset    = 1'b1;
        en       = 1'b0;
        d        = 3'b010;

        // Reset loads all-ones regardless of d
        step();
        check_value("reset_value", q, 3'b111);
`ifdef FF_D_QN_EN
        check_value("qn_after_reset", qn, 3'b000);
`endif

        // Load sequence, one-cycle latency
        reset = 1'b0;
        en    = 1'b1;
        d     = 3'b110;
        step();
        check_value("load_110", q, 3'b110);
        d = 3'b101;
        step();
        check_value("load_101", q, 3'b101);
        d = 3'b000;
        step();
        check_value("load_000", q, 3'b000);

        // Hold with d toggling
        d = 3'b101;
        step();
        check_value("load_101_again", q, 3'b101);
        en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            d = (i % 2 == 0) ? 3'b010 : 3'b111;
            step();
            check_value($sformatf("hold_%0d", i), q, 3'b101);
        end

        // Falling edge must not update q
        en = 1'b1;
        d  = 3'b011;
        @(negedge clock);
        #1;
        check_value("no_update_on_negedge", q, 3'b101);
        step();
        check_value("load_011", q, 3'b011);
`ifdef FF_D_QN_EN
        check_value("qn_after_load_011", qn, 3'b100);
`endif

        // Reset outranks enable at the same edge
        reset = 1'b1;
        en    = 1'b1;
        d     = 3'b000;
        step();
        check_value("reset_over_en", q, 3'b111);

        // d/en changes without an edge leave q alone
        reset = 1'b0;
        d     = 3'b010;
        #3;
        d     = 3'b001;
        #1;
        check_value("no_edge_d_change", q, 3'b111);
        step();
        check_value("resume_after_reset", q, 3'b001);

        // Reset pulse entirely between edges has no effect
        en = 1'b0;
        #2;
        reset = 1'b1;
        #2;
        reset = 1'b0;
        #1;
        check_value("reset_pulse_no_edge", q, 3'b001);
        step();
        check_value("reset_pulse_after_edge", q, 3'b001);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/ff_d.md
FF_D -- requirements
Module: ff_d

Interface
REQ-001 Parameter WIDTH, default 1, number of stored bits (legal range 1..64).
REQ-002 Parameter RESET_VALUE, default all-ones of WIDTH, value loaded on reset.
REQ-003 Port clock  input  1  single clock; all state updates on its rising edge.
REQ-004 Port reset  input  1  synchronous, active-high reset.
REQ-005 Port en  input  1  load enable; 1 = capture d, 0 = hold.
REQ-006 Port d  input  WIDTH  data to capture.
REQ-007 Port q  output  WIDTH  registered data.
REQ-008 The block SHALL have one clock; reset SHALL be synchronous and active-high.

Function
REQ-009 On a rising clock edge with reset=1, q SHALL become RESET_VALUE regardless of en and d.
REQ-010 On a rising clock edge with reset=0 and en=1, q SHALL become d as sampled at that edge (latency one cycle).
REQ-011 On a rising clock edge with reset=0 and en=0, q SHALL hold its previous value.
REQ-012 q SHALL NOT change between rising edges, including on falling edges or on reset/d/en changes without a clock edge.
REQ-013 reset SHALL take priority over en when both are 1 at the same edge.
REQ-014 Reset asserted mid-operation SHALL override the pending load at that edge; the next edge with reset=0 resumes normal load/hold.
REQ-015 All WIDTH bits SHALL update together; no bit-to-bit skew in cycles.
REQ-016 q SHALL be driven directly from state (no combinational path from d, en or reset to q).
REQ-017 Before the first reset edge, q is undefined; users SHALL reset before relying on q.

Reset
REQ-018 Reset SHALL be sampled only on the rising edge of clock; asynchronous pulses without an edge SHALL have no effect.
REQ-019 After reset with default parameters and WIDTH=3, q SHALL equal 3'b111.

Configuration
REQ-020 Macro FF_D_QN_EN, when defined, SHALL add output port qn (WIDTH bits) equal to the bitwise inverse of q at all times, reset value ~RESET_VALUE.
REQ-021 Without FF_D_QN_EN, port qn SHALL not exist and behaviour of q SHALL be identical.

Structure
REQ-022 Shared package ff_d_pkg SHALL hold the WIDTH default, the maximum-width constant (64) and a function producing the default all-ones reset value for a given width.
REQ-023 One sub-module ff_d_bit (single-bit cell: clock, reset, en, d, reset bit, q) SHALL be instantiated WIDTH times via a generate loop.
REQ-024 An elaboration-time check SHALL reject WIDTH outside 1..64.

Verification
REQ-025 WIDTH=3, reset=1 for one edge, d=3'b010 -> q=3'b111 after the edge.
REQ-026 reset=0, en=1, d sequence 3'b110, 3'b101, 3'b000 on three edges -> q follows one edge later: 110, 101, 000.
REQ-027 q=3'b101, en=0, d toggled each cycle for 4 edges -> q stays 3'b101.
REQ-028 reset=1 and en=1 with d=3'b000 at the same edge -> q=3'b111; d changed between edges with no edge -> q unchanged.
REQ-029 reset pulsed high and low entirely between two rising edges -> q unchanged.
REQ-030 With FF_D_QN_EN defined, after reset qn=3'b000 and after loading d=3'b011, qn=3'b100.
